// File: rtl/cursor_ctrl.sv
// Cursor and turn sequencer for the Amazons board: moves the cursor from key events and
// latches queen, destination and arrow squares, then hands the move off via valid/ack.
module cursor_ctrl #(
  parameter int unsigned N  = 10,
  parameter int unsigned CW = 4,
  parameter int unsigned X0 = 0,
  parameter int unsigned Y0 = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    od,
  input  logic          ena,
  input  logic          sel_ok,
  input  logic          move_ack,
  output logic [CW-1:0] cur_x,
  output logic [CW-1:0] cur_y,
  output logic [1:0]    phase,
  output logic [CW-1:0] src_x,
  output logic [CW-1:0] src_y,
  output logic [CW-1:0] dst_x,
  output logic [CW-1:0] dst_y,
  output logic [CW-1:0] arw_x,
  output logic [CW-1:0] arw_y,
  output logic          move_valid,
  output logic          err
);

  typedef enum logic [1:0] {StPick = 2'd0, StDest = 2'd1, StArrow = 2'd2, StWait = 2'd3} phase_e;

  localparam logic [2:0] KeyUp    = 3'd1;
  localparam logic [2:0] KeyDown  = 3'd2;
  localparam logic [2:0] KeyLeft  = 3'd3;
  localparam logic [2:0] KeyRight = 3'd4;
  localparam logic [2:0] KeyEnter = 3'd5;

  localparam logic [CW-1:0] MaxCoord = CW'(N - 1);
  localparam logic [CW-1:0] InitX    = CW'(X0);
  localparam logic [CW-1:0] InitY    = CW'(Y0);

  phase_e        phase_q, phase_d;
  logic [CW-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [CW-1:0] src_x_q, src_x_d, src_y_q, src_y_d;
  logic [CW-1:0] dst_x_q, dst_x_d, dst_y_q, dst_y_d;
  logic [CW-1:0] arw_x_q, arw_x_d, arw_y_q, arw_y_d;
  logic          err_q, err_d;
  logic          mv_q, mv_d;
  logic          on_src;

  assign on_src = (cur_x_q == src_x_q) && (cur_y_q == src_y_q);

  always_comb begin
    phase_d = phase_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    src_x_d = src_x_q;
    src_y_d = src_y_q;
    dst_x_d = dst_x_q;
    dst_y_d = dst_y_q;
    arw_x_d = arw_x_q;
    arw_y_d = arw_y_q;
    err_d   = 1'b0;

    if (phase_q == StWait) begin
      // Key events are dropped while the move waits to be consumed.
      if (move_ack) phase_d = StPick;
    end else if (ena) begin
      case (od)
        KeyUp:    if (cur_y_q != '0)       cur_y_d = cur_y_q - 1'b1;
        KeyDown:  if (cur_y_q != MaxCoord) cur_y_d = cur_y_q + 1'b1;
        KeyLeft:  if (cur_x_q != '0)       cur_x_d = cur_x_q - 1'b1;
        KeyRight: if (cur_x_q != MaxCoord) cur_x_d = cur_x_q + 1'b1;
        KeyEnter: begin
          unique case (phase_q)
            StPick: begin
              if (sel_ok) begin
                src_x_d = cur_x_q;
                src_y_d = cur_y_q;
                phase_d = StDest;
              end else begin
                err_d = 1'b1;
              end
            end
            StDest: begin
              // Re-selecting the queen cancels the pick regardless of sel_ok.
              if (on_src) begin
                phase_d = StPick;
              end else if (sel_ok) begin
                dst_x_d = cur_x_q;
                dst_y_d = cur_y_q;
                phase_d = StArrow;
              end else begin
                err_d = 1'b1;
              end
            end
            StArrow: begin
              if (sel_ok) begin
                arw_x_d = cur_x_q;
                arw_y_d = cur_y_q;
                phase_d = StWait;
              end else begin
                err_d = 1'b1;
              end
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end

    mv_d = (phase_d == StWait);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= StPick;
      cur_x_q <= InitX;
      cur_y_q <= InitY;
      src_x_q <= '0;
      src_y_q <= '0;
      dst_x_q <= '0;
      dst_y_q <= '0;
      arw_x_q <= '0;
      arw_y_q <= '0;
      err_q   <= 1'b0;
      mv_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      src_x_q <= src_x_d;
      src_y_q <= src_y_d;
      dst_x_q <= dst_x_d;
      dst_y_q <= dst_y_d;
      arw_x_q <= arw_x_d;
      arw_y_q <= arw_y_d;
      err_q   <= err_d;
      mv_q    <= mv_d;
    end
  end

  assign cur_x      = cur_x_q;
  assign cur_y      = cur_y_q;
  assign phase      = phase_q;
  assign src_x      = src_x_q;
  assign src_y      = src_y_q;
  assign dst_x      = dst_x_q;
  assign dst_y      = dst_y_q;
  assign arw_x      = arw_x_q;
  assign arw_y      = arw_y_q;
  assign move_valid = mv_q;
  assign err        = err_q;

endmodule

// File: tb/tb_cursor_ctrl.sv
// Scoreboard bench for cursor_ctrl: a reference model predicts every post-edge output set,
// and a negedge monitor pops and compares each prediction against the DUT.
module tb_cursor_ctrl;
  localparam int N = 10;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, ena, sel_ok, move_ack;
  logic [2:0]    od;
  logic [CW-1:0] cur_x, cur_y, src_x, src_y, dst_x, dst_y, arw_x, arw_y;
  logic [1:0]    phase;
  logic          move_valid, err;

  cursor_ctrl #(.N(N), .CW(CW), .X0(0), .Y0(0)) dut (
    .clk(clk), .rst(rst), .od(od), .ena(ena), .sel_ok(sel_ok), .move_ack(move_ack),
    .cur_x(cur_x), .cur_y(cur_y), .phase(phase),
    .src_x(src_x), .src_y(src_y), .dst_x(dst_x), .dst_y(dst_y),
    .arw_x(arw_x), .arw_y(arw_y), .move_valid(move_valid), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cx, cy, ph, sx, sy, dx, dy, ax, ay, mv, er;
  } exp_t;

  exp_t exp_q[$];
  exp_t m;  // model state
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  // Model: turn rules applied directly to integer coordinates.
  task automatic model_update(input bit r, input int k, input bit e, input bit s,
                              input bit a);
    int old_ph;
    old_ph = m.ph;
    if (r) begin
      m = '{cx: 0, cy: 0, ph: 0, sx: 0, sy: 0, dx: 0, dy: 0, ax: 0, ay: 0, mv: 0, er: 0};
      return;
    end
    m.er = 0;
    if (old_ph == 3) begin
      if (a) m.ph = 0;
    end else if (e) begin
      if (k == 1 && m.cy > 0) m.cy--;
      if (k == 2 && m.cy < N - 1) m.cy++;
      if (k == 3 && m.cx > 0) m.cx--;
      if (k == 4 && m.cx < N - 1) m.cx++;
      if (k == 5) begin
        if (old_ph == 0) begin
          if (s) begin m.sx = m.cx; m.sy = m.cy; m.ph = 1; end
          else m.er = 1;
        end else if (old_ph == 1) begin
          if (m.cx == m.sx && m.cy == m.sy) m.ph = 0;
          else if (s) begin m.dx = m.cx; m.dy = m.cy; m.ph = 2; end
          else m.er = 1;
        end else begin
          if (s) begin m.ax = m.cx; m.ay = m.cy; m.ph = 3; end
          else m.er = 1;
        end
      end
    end
    m.mv = (m.ph == 3) ? 1 : 0;
  endtask

  task automatic step(input bit r, input int k, input bit e, input bit s, input bit a);
    rst = r; od = 3'(k); ena = e; sel_ok = s; move_ack = a;
    model_update(r, k, e, s, a);
    @(posedge clk);
    exp_q.push_back(m);
    #1;
  endtask

  task automatic keys(input int k, input int n, input bit s);
    for (int i = 0; i < n; i++) step(1'b0, k, 1'b1, s, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (int'(cur_x) != e.cx || int'(cur_y) != e.cy || int'(phase) != e.ph ||
          int'(src_x) != e.sx || int'(src_y) != e.sy || int'(dst_x) != e.dx ||
          int'(dst_y) != e.dy || int'(arw_x) != e.ax || int'(arw_y) != e.ay ||
          int'(move_valid) != e.mv || int'(err) != e.er) begin
        n_errors++;
        $display("FAIL outputs cyc=%0d got cur=(%0d,%0d) ph=%0d src=(%0d,%0d) dst=(%0d,%0d) arw=(%0d,%0d) mv=%0d err=%0d exp cur=(%0d,%0d) ph=%0d src=(%0d,%0d) dst=(%0d,%0d) arw=(%0d,%0d) mv=%0d err=%0d",
                 cyc, cur_x, cur_y, phase, src_x, src_y, dst_x, dst_y, arw_x, arw_y,
                 move_valid, err, e.cx, e.cy, e.ph, e.sx, e.sy, e.dx, e.dy, e.ax, e.ay,
                 e.mv, e.er);
      end
    end
  end

  initial begin
    m = '{cx: 0, cy: 0, ph: 0, sx: 0, sy: 0, dx: 0, dy: 0, ax: 0, ay: 0, mv: 0, er: 0};
    step(1'b1, 0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5, 1'b1, 1'b1, 1'b1);
    // Saturation at the far corner, then back to origin.
    keys(4, 12, 1'b0);
    keys(2, 12, 1'b0);
    keys(3, 12, 1'b0);
    keys(1, 12, 1'b0);
    // Rejected then accepted pick; cancel on src.
    keys(5, 2, 1'b0);
    keys(5, 1, 1'b1);
    keys(5, 1, 1'b0);
    // Full turn: src (3,0), dst (5,2), arw (5,1).
    keys(4, 3, 1'b0);
    keys(5, 1, 1'b1);
    keys(4, 2, 1'b0);
    keys(2, 2, 1'b0);
    keys(5, 1, 1'b1);
    keys(1, 1, 1'b0);
    keys(5, 1, 1'b1);
    keys(3, 2, 1'b1);
    keys(5, 1, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4, 1'b1, 1'b1, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0, 1'b0);
    // Reset arriving with an ENTER in ARROW.
    keys(5, 1, 1'b1);
    keys(4, 1, 1'b0);
    keys(5, 1, 1'b1);
    step(1'b1, 5, 1'b1, 1'b1, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0, 1'b0);
    // Ignored codes and stray ack.
    keys(6, 2, 1'b1);
    keys(7, 2, 1'b1);
    keys(0, 1, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    // Random traffic biased toward ENTER so turns complete.
    for (int i = 0; i < 3000; i++) begin
      int k;
      k = ($urandom_range(0, 3) == 0) ? 5 : int'($urandom_range(0, 7));
      step(($urandom_range(0, 99) < 2), k, ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 3) == 0));
    end
    step(1'b0, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d predictions left unchecked, required 0", exp_q.size());
    end
    #2;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/cursor_ctrl.md
# cursor_ctrl

Downstream consumer of the debounced key-event stream (3-bit direction/enter code plus one-cycle enable). Maintains the player's cursor on the N×N Amazons board and sequences one full turn: pick queen, pick destination, pick arrow square. Delivers the completed move to the board/game logic with a valid/ack handshake. Legality is judged outside this block; `sel_ok` reports whether the current cursor cell is acceptable for the current phase.

## Interface
Parameters:
- `N`, 10, board side length; coordinates run 0..N-1.
- `CW`, 4, coordinate width; must satisfy 2^CW >= N.
- `X0`, 0, cursor column after reset.
- `Y0`, 0, cursor row after reset.

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `od`  in  3  key code: 0 NULL, 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT, 5 ENTER; 6/7 ignored.
- `ena`  in  1  one-cycle strobe; `od` meaningful only when high.
- `sel_ok`  in  1  combinational verdict from board logic on (`cur_x`,`cur_y`) for current `phase`.
- `move_ack`  in  1  board logic has consumed the move.
- `cur_x`, `cur_y`  out  CW  cursor column / row (row 0 = top).
- `phase`  out  2  0 PICK, 1 DEST, 2 ARROW, 3 WAIT.
- `src_x`, `src_y`  out  CW  latched queen square.
- `dst_x`, `dst_y`  out  CW  latched destination square.
- `arw_x`, `arw_y`  out  CW  latched arrow square.
- `move_valid`  out  1  high while in WAIT; move fields stable.
- `err`  out  1  one-cycle pulse: ENTER rejected.

## Operation
- Event accepted only when `ena`=1 and `phase` != WAIT. Codes 0, 6, 7 are no-ops.
- Movement: UP y-1, DOWN y+1, LEFT x-1, RIGHT x+1. Saturating at 0 and N-1 (no wrap); move at edge leaves cursor unchanged, no `err`.
- Movement is allowed in PICK, DEST, ARROW; never changes phase or latched fields.
- ENTER handling by phase:
  - PICK: `sel_ok`=1 → latch cursor into src, go DEST. Else `err`, stay.
  - DEST: cursor == src → cancel, go PICK (src kept but meaningless, no `err`, `sel_ok` ignored). Else `sel_ok`=1 → latch dst, go ARROW. Else `err`, stay.
  - ARROW: `sel_ok`=1 → latch arw, go WAIT. Else `err`, stay. Arrow on src is legal (vacated square); decided by `sel_ok` only.
- WAIT: all key events dropped (no cursor motion, no `err`). `move_ack`=1 → PICK. Cursor position retained across turns.
- `move_ack` outside WAIT ignored.
- `move_valid` = (phase == WAIT), registered.

## Timing
- Reset (`rst`=1 at posedge): `cur_x`=X0, `cur_y`=Y0, `phase`=PICK, all src/dst/arw=0, `move_valid`=0, `err`=0. Reset overrides any simultaneous `ena` or `move_ack`; reset mid-turn discards partial move.
- All outputs registered. Event at posedge k (ena=1) → cursor/phase/latched fields/`err` updated and visible after edge k.
- `sel_ok` sampled at the same edge as the ENTER; it reflects the cursor value before that edge.
- `err` high exactly one cycle per rejected ENTER; back-to-back rejected ENTERs give back-to-back pulses.
- Third accepted ENTER at edge k → `move_valid`=1 from edge k; src/dst/arw stable until the next accepted ENTER in a later turn.
- `move_ack` sampled at edge m with `move_valid`=1 → `phase`=PICK, `move_valid`=0 after edge m. An `ena` at edge m is dropped (phase was WAIT).
- Minimum turn: 3 accepted ENTER strobes, no movement required.

## Test plan
- Reset then 12×RIGHT, 12×DOWN (N=10) → cursor saturates at (9,9); `err` never asserts; `phase`=0.
- From (0,0): ENTER with `sel_ok`=0 → `err` one cycle, `phase`=0; ENTER with `sel_ok`=1 → src=(0,0), `phase`=1.
- In DEST, cursor on src, ENTER (`sel_ok`=0) → `phase`=0, no `err`.
- Full turn: src (3,0), RIGHT×2 DOWN×2 ENTER → dst (5,2), UP ENTER → arw (5,1); `move_valid`=1 from that edge; keys in WAIT leave cursor (5,1); `move_ack` 1 cycle → `phase`=0, `move_valid`=0 next edge.
- `ena`+ENTER with `rst`=1 in ARROW → all outputs at reset values next cycle; `move_valid` never asserts.
- `od`=6 and 7 with `ena`=1 → no state change; `move_ack` pulsed in PICK → ignored.
